shift_rows: RTL and testbench



---
 rtl/shift_rows_pkg.sv | 22 ++
 rtl/shift_rows_perm.sv | 25 ++
 rtl/shift_rows.sv | 62 ++++++
 tb/tb_shift_rows.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_rows_pkg.sv
// rtl/shift_rows_pkg.sv - shared constants and byte-mapping helper for the AES ShiftRows stage
// Contents: NB, STATE_W, MODE_ENC/MODE_DEC, src_byte(r, c, dec)
package shift_rows_pkg;

    localparam int   NB      = 4;
    localparam int   STATE_W = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Source byte index feeding output byte (row r, column c).
    // Byte index k = r + 4c, so k is simply {c, r}. The 2-bit column sum
    // wraps naturally, which gives the mod-4 rotation for free.
    function automatic logic [3:0] src_byte(input logic [1:0] r,
                                            input logic [1:0] c,
                                            input logic       dec);
        logic [1:0] sc;
        sc = (dec == MODE_DEC) ? (c - r) : (c + r);
        return {sc, r};
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational ShiftRows / InvShiftRows byte permutation
// Ports:
//   state     in  [0:127]  input AES state, byte k at bits [8k:8k+7]
//   dec       in  1        0 = ShiftRows, 1 = InvShiftRows
//   new_state out [0:127]  permuted state
module shift_rows_perm
    import shift_rows_pkg::*;
(
    input  logic [0:STATE_W-1] state,
    input  logic               dec,
    output logic [0:STATE_W-1] new_state
);

    for (genvar r = 0; r < NB; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int K  = r + NB * c;
            localparam int SE = int'(src_byte(2'(r), 2'(c), MODE_ENC));
            localparam int SD = int'(src_byte(2'(r), 2'(c), MODE_DEC));

            // With dec tied to a constant, one leg of this mux folds away.
            assign new_state[8*K +: 8] = dec ? state[8*SD +: 8] : state[8*SE +: 8];
        end
    end

endmodule

// File: rtl/shift_rows.sv
// rtl/shift_rows.sv - registered AES ShiftRows stage with valid/ready flow control
// Ports:
//   clk       in  1        clock, rising edge
//   rst       in  1        synchronous active-high reset
//   in_valid  in  1        state holds a valid input
//   in_ready  out 1        stage accepts input this cycle
//   state     in  [0:127]  input AES state
//   dec       in  1        inverse shift for this transfer (SHIFT_ROWS_RUNTIME_MODE_EN only)
//   out_valid out 1        new_state is valid
//   out_ready in  1        downstream accepts output
//   new_state out [0:127]  permuted state
// Macro SHIFT_ROWS_RUNTIME_MODE_EN: direction chosen per transfer by dec
// instead of the ENC_DEC parameter.
module shift_rows
    import shift_rows_pkg::*;
#(
    parameter logic ENC_DEC = MODE_ENC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:STATE_W-1] state,
`ifdef SHIFT_ROWS_RUNTIME_MODE_EN
    input  logic               dec,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:STATE_W-1] new_state
);

    logic [0:STATE_W-1] perm_state;
    logic               perm_dec;

`ifdef SHIFT_ROWS_RUNTIME_MODE_EN
    assign perm_dec = dec;
`else
    assign perm_dec = ENC_DEC;
`endif

    shift_rows_perm u_perm (
        .state     (state),
        .dec       (perm_dec),
        .new_state (perm_state)
    );

    // The register can take new data whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            new_state <= '0;
        end else if (in_valid && in_ready) begin
            new_state <= perm_state;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_rows.sv
// tb/tb_shift_rows.sv - testbench for shift_rows (encrypt and decrypt instances)
module tb_shift_rows;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [0:127] state;

    logic         enc_in_ready, enc_out_valid;
    logic [0:127] enc_new_state;
    logic         dec_in_ready, dec_out_valid;
    logic [0:127] dec_new_state;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    shift_rows #(.ENC_DEC(1'b0)) u_enc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (enc_in_ready),
        .state     (state),
`ifdef SHIFT_ROWS_RUNTIME_MODE_EN
        .dec       (1'b0),
`endif
        .out_valid (enc_out_valid),
        .out_ready (out_ready),
        .new_state (enc_new_state)
    );

    shift_rows #(.ENC_DEC(1'b1)) u_dec (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (dec_in_ready),
        .state     (state),
`ifdef SHIFT_ROWS_RUNTIME_MODE_EN
        .dec       (1'b1),
`endif
        .out_valid (dec_out_valid),
        .out_ready (out_ready),
        .new_state (dec_new_state)
    );

    // Reference: split into 16 bytes (byte 0 = MSB), apply row rotation formula.
    function automatic logic [127:0] ref_perm(input logic [127:0] s, input bit d);
        logic [7:0]   b [16];
        logic [7:0]   o [16];
        logic [127:0] res;
        for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int sc;
                sc = d ? (c - r + 4) % 4 : (c + r) % 4;
                o[r + 4*c] = b[r + 4*sc];
            end
        end
        for (int k = 0; k < 16; k++) res[127 - 8*k -: 8] = o[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] a, b, v;
        logic [127:0] q [$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_out_valid", {127'd0, enc_out_valid}, 128'd0);
        check("reset_new_state", enc_new_state, 128'd0);
        check("reset_in_ready", {127'd0, enc_in_ready}, 128'd1);
        check("reset_dec_out_valid", {127'd0, dec_out_valid}, 128'd0);

        // Directed vectors, one per cycle, downstream always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state = 128'h000102030405060708090a0b0c0d0e0f;
        tick();
        check("idx_enc_valid", {127'd0, enc_out_valid}, 128'd1);
        check("idx_enc", enc_new_state, 128'h00050a0f04090e03080d02070c01060b);
        check("idx_dec", dec_new_state, 128'h000d0a0704010e0b0805020f0c090603);

        state = 128'hd42711aee0bf98f1b8b45de51e415230;
        tick();
        check("fips_enc", enc_new_state, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check("fips_in_dec_model", dec_new_state, ref_perm(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1));

        state = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        tick();
        check("fips_dec", dec_new_state, 128'hd42711aee0bf98f1b8b45de51e415230);
        check("fips_out_enc_model", enc_new_state, ref_perm(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0));

        // Drain.
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", {127'd0, enc_out_valid}, 128'd0);

        // Backpressure: A accepted, B waiting while out_ready is low for 3 cycles.
        a = rand128();
        b = rand128();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        state     = a;
        tick();
        state = b;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_data", i), enc_new_state, ref_perm(a, 1'b0));
            check($sformatf("stall%0d_valid", i), {127'd0, enc_out_valid}, 128'd1);
            check($sformatf("stall%0d_in_ready", i), {127'd0, enc_in_ready}, 128'd0);
            check($sformatf("stall%0d_dec_data", i), dec_new_state, ref_perm(a, 1'b1));
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {127'd0, enc_in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        check("bp_second_data", enc_new_state, ref_perm(b, 1'b0));
        check("bp_second_valid", {127'd0, enc_out_valid}, 128'd1);
        check("bp_second_dec", dec_new_state, ref_perm(b, 1'b1));
        tick();
        check("bp_no_dup", {127'd0, enc_out_valid}, 128'd0);

        // Streaming: one random state per cycle at full throughput.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = rand128();
            state = v;
            q.push_back(v);
            tick();
            v = q.pop_front();
            check($sformatf("stream%0d_valid", i), {127'd0, enc_out_valid}, 128'd1);
            check($sformatf("stream%0d_enc", i), enc_new_state, ref_perm(v, 1'b0));
            check($sformatf("stream%0d_dec", i), dec_new_state, ref_perm(v, 1'b1));
        end
        in_valid = 1'b0;
        tick();

        // Reset while stalled discards the held state.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        state     = rand128();
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", {127'd0, enc_out_valid}, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_stall_valid", {127'd0, enc_out_valid}, 128'd0);
        check("rst_stall_data", enc_new_state, 128'd0);
        check("rst_stall_in_ready", {127'd0, enc_in_ready}, 128'd1);
        check("rst_stall_dec_data", dec_new_state, 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
